emu_scan_ctrl: RTL and testbench

// - Host-side master for the emulator scan chains: pauses the DUT, then drains (save) or fills (load) the
//   FF chain and then the RAM chain, one DATA_WIDTH word per shift, over valid/ready streams.
// - Drives the $EMU$FF$* / $EMU$RAM$* ports of EMU_DUT and the pause input of the DUT clock gates; sits

---
 rtl/emu_scan_ctrl_if.sv | 41 ++++
 rtl/emu_scan_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_emu_scan_ctrl.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/emu_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : emu_scan_ctrl_if
//  Description : Host-facing handshake bundle for emu_scan_ctrl. It carries the
//                command channel (cmd_valid/cmd_ready/cmd_load/cmd_hold), the
//                resume pulse, the save stream (out_*) and the load stream
//                (in_*).
//                  master : host / checkpoint DMA side
//                  slave  : scan controller side
//  Revision    : 1.0  initial release
// ============================================================================
interface emu_scan_ctrl_if #(
  parameter int DATA_WIDTH = 64
);
  // command channel
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_load;
  logic                  cmd_hold;
  logic                  resume;
  // save stream (controller -> host)
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  // load stream (host -> controller)
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;

  modport master (
    output cmd_valid, cmd_load, cmd_hold, resume, out_ready, in_valid, in_data,
    input  cmd_ready, out_valid, out_data, out_last, in_ready
  );

  modport slave (
    input  cmd_valid, cmd_load, cmd_hold, resume, out_ready, in_valid, in_data,
    output cmd_ready, out_valid, out_data, out_last, in_ready
  );
endinterface
`default_nettype wire

// File: rtl/emu_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : emu_scan_ctrl
//  Description : Host-side scan master for the emulator. On a command it
//                pauses the emulated design, waits SETTLE cycles, then drains
//                (save) or fills (load) the FF chain followed by the RAM chain,
//                one DATA_WIDTH word per handshake beat.
//  Ports       : clk, rst          clock and synchronous active-high reset
//                bus (slave)       command, resume, save and load streams
//                pause             clock-gate pause for the DUT/reference
//                ff_se/ff_dir      FF chain shift enable / input select
//                ff_sdi/ff_sdo     FF chain scan data in / out
//                ram_se/ram_sd     RAM chain shift enable / scan-in select
//                ram_sdi/ram_sdo   RAM chain scan data in / out
//                busy, done        activity flag, completion pulse
//                checksum          running checksum of shifted words
//  Options     : EMU_SCAN_CHECKSUM_EN  enables the checksum (else tied to 0)
//  Revision    : 1.0  initial release
// ============================================================================
module emu_scan_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int FF_WORDS   = 16,
  parameter int RAM_WORDS  = 64,
  parameter int SETTLE     = 2,
  parameter int CNT_W      = 16
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  emu_scan_ctrl_if.slave             bus,
  output logic                       pause,
  output logic                       ff_se,
  output logic                       ff_dir,
  output logic [DATA_WIDTH-1:0]      ff_sdi,
  input  wire logic [DATA_WIDTH-1:0] ff_sdo,
  output logic                       ram_se,
  output logic                       ram_sd,
  output logic [DATA_WIDTH-1:0]      ram_sdi,
  input  wire logic [DATA_WIDTH-1:0] ram_sdo,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                checksum
);

  localparam logic [CNT_W-1:0] FF_LAST     = CNT_W'(FF_WORDS - 1);
  localparam logic [CNT_W-1:0] RAM_LAST    = CNT_W'((RAM_WORDS > 0) ? RAM_WORDS - 1 : 0);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PAUSE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_FF     = 3'd3,
    ST_RAM    = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_q, load_d;
  logic             hold_q, hold_d;
  logic             pause_q, pause_d;
  logic             done_q, done_d;

  logic             accept;
  logic             in_ff;
  logic             in_ram;
  logic             beat_rdy;
  logic             shift;

  assign accept   = bus.cmd_valid && (state_q == ST_IDLE);
  assign in_ff    = (state_q == ST_FF);
  assign in_ram   = (state_q == ST_RAM);
  // A beat moves only when the host side of the active stream is ready.
  assign beat_rdy = load_q ? bus.in_valid : bus.out_ready;
  assign shift    = (in_ff || in_ram) && beat_rdy;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load_d  = load_q;
    hold_d  = hold_q;
    pause_d = pause_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A new command wins over resume, so a held pause is never dropped
        // under a command that is starting.
        if (accept) begin
          state_d = ST_PAUSE;
          load_d  = bus.cmd_load;
          hold_d  = bus.cmd_hold;
          pause_d = 1'b1;
          cnt_d   = '0;
        end else if (bus.resume) begin
          pause_d = 1'b0;
        end
      end
      ST_PAUSE: begin
        state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = '0;
          state_d = ST_FF;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_FF: begin
        if (shift) begin
          if (cnt_q == FF_LAST) begin
            cnt_d = '0;
            if (RAM_WORDS == 0) begin
              state_d = ST_IDLE;
              pause_d = hold_q;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RAM;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_RAM: begin
        if (shift) begin
          if (cnt_q == RAM_LAST) begin
            cnt_d   = '0;
            state_d = ST_IDLE;
            pause_d = hold_q;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      load_q  <= 1'b0;
      hold_q  <= 1'b0;
      pause_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      load_q  <= load_d;
      hold_q  <= hold_d;
      pause_q <= pause_d;
      done_q  <= done_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign busy          = (state_q != ST_IDLE);
  assign pause         = pause_q;
  assign done          = done_q;

  assign ff_se   = in_ff  && beat_rdy;
  assign ram_se  = in_ram && beat_rdy;
  // Save keeps ff_dir low so the FF chain recirculates and survives the drain.
  assign ff_dir  = load_q && busy;
  assign ram_sd  = load_q && in_ram;

  assign bus.out_valid = (in_ff || in_ram) && !load_q;
  assign bus.in_ready  = (in_ff || in_ram) &&  load_q;
  assign bus.out_data  = (!load_q && in_ff)  ? ff_sdo  :
                         (!load_q && in_ram) ? ram_sdo : '0;
  assign bus.out_last  = !load_q &&
                         ((in_ram && (cnt_q == RAM_LAST)) ||
                          (in_ff  && (cnt_q == FF_LAST) && (RAM_WORDS == 0)));
  assign ff_sdi  = (load_q && in_ff)  ? bus.in_data : '0;
  assign ram_sdi = (load_q && in_ram) ? bus.in_data : '0;

  // --------------------------------------------------------------------------
  // Optional checksum over every word that crosses the chain boundary
  // --------------------------------------------------------------------------
`ifdef EMU_SCAN_CHECKSUM_EN
  localparam int NSLICE = (DATA_WIDTH + 31) / 32;

  function automatic logic [31:0] fold32(input logic [DATA_WIDTH-1:0] w);
    logic [NSLICE*32-1:0] padded;
    logic [31:0]          acc;
    padded                 = '0;
    padded[DATA_WIDTH-1:0] = w;
    acc                    = '0;
    for (int i = 0; i < NSLICE; i++) begin
      acc = acc ^ padded[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [31:0]           csum_q, csum_d;
  logic [DATA_WIDTH-1:0] shift_word;

  assign shift_word = load_q ? bus.in_data : (in_ff ? ff_sdo : ram_sdo);

  always_comb begin
    csum_d = csum_q;
    if (accept) begin
      csum_d = '0;
    end else if (shift) begin
      csum_d = {csum_q[30:0], csum_q[31]} ^ fold32(shift_word);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_emu_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_emu_scan_ctrl
//  Description : Self-checking bench for emu_scan_ctrl. A behavioural model of
//                the FF and RAM scan chains stands in for the emulated design;
//                expected streams, chain contents, timing and checksum are
//                derived from the command sequence itself.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_emu_scan_ctrl;

  localparam int DW   = 64;
  localparam int FFW  = 4;
  localparam int RAMW = 2;
  localparam int ST   = 2;
  localparam int CW   = 8;
  localparam int NW   = FFW + RAMW;

  logic clk = 1'b0;
  logic rst;
  logic env_init;
  always #5 clk = ~clk;

  emu_scan_ctrl_if #(.DATA_WIDTH(DW)) bus ();

  logic          pause, ff_se, ff_dir, ram_se, ram_sd, busy, done;
  logic [DW-1:0] ff_sdi, ff_sdo, ram_sdi, ram_sdo;
  logic [31:0]   checksum;

  emu_scan_ctrl #(
    .DATA_WIDTH(DW), .FF_WORDS(FFW), .RAM_WORDS(RAMW), .SETTLE(ST), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .pause(pause), .ff_se(ff_se), .ff_dir(ff_dir), .ff_sdi(ff_sdi), .ff_sdo(ff_sdo),
    .ram_se(ram_se), .ram_sd(ram_sd), .ram_sdi(ram_sdi), .ram_sdo(ram_sdo),
    .busy(busy), .done(done), .checksum(checksum)
  );

  // Emulated chains: word [N-1] is at the scan-out end, word [0] at scan-in.
  logic [DW-1:0] ff_mem  [FFW];
  logic [DW-1:0] ram_mem [RAMW];
  assign ff_sdo  = ff_mem[FFW-1];
  assign ram_sdo = ram_mem[RAMW-1];

  always @(posedge clk) begin
    if (env_init) begin
      for (int i = 0; i < FFW; i++)  ff_mem[i]  <= {32'hF0F0_0000 + 32'(i), 32'(i * 7 + 3)};
      for (int i = 0; i < RAMW; i++) ram_mem[i] <= {32'hA5A5_0000 + 32'(i), 32'(i * 13 + 1)};
    end else begin
      if (ff_se) begin
        for (int i = FFW - 1; i > 0; i--) ff_mem[i] <= ff_mem[i-1];
        ff_mem[0] <= ff_dir ? ff_sdi : ff_sdo;
      end
      if (ram_se) begin
        for (int i = RAMW - 1; i > 0; i--) ram_mem[i] <= ram_mem[i-1];
        ram_mem[0] <= ram_sd ? ram_sdi : ram_sdo;
      end
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Rotate-left-by-one then xor in both 32-bit halves of the word.
  function automatic logic [31:0] ref_csum(input logic [DW-1:0] ws [$]);
    logic [31:0] c;
    c = 32'h0;
    foreach (ws[i]) c = ((c << 1) | (c >> 31)) ^ ws[i][31:0] ^ ws[i][63:32];
    return c;
  endfunction

  // Issues one command and follows it to completion. mode: 0 always ready,
  // 1 ready pattern 1,0,0 repeating, 2 random. seq: payload is 1..NW.
  task automatic run_cmd(input string nm, input logic ld, input logic hold,
                         input logic with_resume, input int mode, input logic seq,
                         input int exp_beats, input logic exp_pause);
    logic [DW-1:0] exp_q [$];
    logic [DW-1:0] ld_q  [$];
    logic [DW-1:0] got_q [$];
    int k, nbeats, first_k, last_k, done_k, last_cnt, last_at, se_err, pause_err;
    logic hs;
    nbeats = 0; first_k = -1; last_k = -1; done_k = -1;
    last_cnt = 0; last_at = -1; se_err = 0; pause_err = 0;

    for (int i = 0; i < NW; i++) ld_q.push_back(seq ? DW'(i + 1) : {$urandom, $urandom});
    if (ld) exp_q = ld_q;
    else if (seq) for (int i = 0; i < NW; i++) exp_q.push_back(DW'(i + 1));
    else begin
      for (int i = FFW - 1; i >= 0; i--)  exp_q.push_back(ff_mem[i]);
      for (int i = RAMW - 1; i >= 0; i--) exp_q.push_back(ram_mem[i]);
    end

    bus.cmd_valid = 1'b1; bus.cmd_load = ld; bus.cmd_hold = hold; bus.resume = with_resume;
    @(negedge clk);
    chk({nm, "/cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0; bus.resume = 1'b0;
    bus.cmd_load = 1'($urandom); bus.cmd_hold = 1'($urandom);
    chk({nm, "/pause_on_accept"}, 64'(pause), 64'd1);

    k = 0;
    while (k < 400) begin
      case (mode)
        0:       begin bus.out_ready = 1'b1;            bus.in_valid = 1'b1; end
        1:       begin bus.out_ready = (k % 3 == 0);    bus.in_valid = (k % 3 == 0); end
        default: begin bus.out_ready = 1'($urandom);    bus.in_valid = 1'($urandom); end
      endcase
      bus.in_data = (nbeats < NW) ? ld_q[nbeats] : {$urandom, $urandom};
      @(negedge clk);
      if (done) begin done_k = k; break; end
      hs = ld ? (bus.in_valid && bus.in_ready) : (bus.out_valid && bus.out_ready);
      if ((ff_se || ram_se) !== hs) se_err++;
      if (!pause || !busy) pause_err++;
      if (hs) begin
        if (nbeats == 0) first_k = k;
        if (!ld) begin
          got_q.push_back(bus.out_data);
          if (bus.out_last) begin last_cnt++; last_at = nbeats; end
        end
        nbeats++;
        last_k = k;
      end
      @(posedge clk); #1;
      k++;
    end

    chk({nm, "/done_seen"}, 64'(done_k >= 0), 64'd1);
    chk({nm, "/se_follows_handshake"}, 64'(se_err), 64'd0);
    chk({nm, "/pause_busy_held"}, 64'(pause_err), 64'd0);
    chk({nm, "/beats"}, 64'(nbeats), 64'(exp_beats));
    if (mode == 0) chk({nm, "/first_beat_cycle"}, 64'(first_k), 64'(1 + ST));
    chk({nm, "/done_latency"}, 64'(done_k), 64'(last_k + 1));
    chk({nm, "/pause_after"}, 64'(pause), 64'(exp_pause));
    chk({nm, "/idle_after"}, 64'({busy, bus.cmd_ready}), 64'b01);
    if (!ld) begin
      chk({nm, "/out_last"}, 64'({last_cnt, last_at}), 64'({32'd1, 32'(exp_beats - 1)}));
      for (int i = 0; i < NW; i++)
        chk({nm, $sformatf("/word%0d", i)}, (i < got_q.size()) ? got_q[i] : 64'hDEAD, exp_q[i]);
    end
    // After save the chains are back in place; after load they hold the payload.
    for (int i = 0; i < FFW; i++)  chk({nm, $sformatf("/ff%0d", i)},  ff_mem[FFW-1-i],  exp_q[i]);
    for (int i = 0; i < RAMW; i++) chk({nm, $sformatf("/ram%0d", i)}, ram_mem[RAMW-1-i], exp_q[FFW+i]);
`ifdef EMU_SCAN_CHECKSUM_EN
    chk({nm, "/checksum"}, 64'(checksum), 64'(ref_csum(exp_q)));
`else
    chk({nm, "/checksum"}, 64'(checksum), 64'd0);
`endif
    @(posedge clk); #1;
    chk({nm, "/done_pulse"}, 64'(done), 64'd0);
  endtask

  typedef struct {
    logic ld;
    logic hold;
    logic with_resume;
    int   mode;
    logic seq;
    int   exp_beats;
    logic exp_pause;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b0, 1'b0, 1'b0, 0, 1'b0, NW, 1'b0}; // plain save, always ready
    vecs[1] = '{1'b0, 1'b0, 1'b0, 1, 1'b0, NW, 1'b0}; // save with 1,0,0 ready
    vecs[2] = '{1'b1, 1'b0, 1'b0, 0, 1'b1, NW, 1'b0}; // load 1..N
    vecs[3] = '{1'b0, 1'b0, 1'b0, 0, 1'b1, NW, 1'b0}; // save returns 1..N
    vecs[4] = '{1'b0, 1'b1, 1'b0, 2, 1'b0, NW, 1'b1}; // held save
    vecs[5] = '{1'b1, 1'b0, 1'b1, 2, 1'b0, NW, 1'b0}; // resume+cmd_valid, load

    rst = 1'b1; env_init = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_load = 1'b0; bus.cmd_hold = 1'b0; bus.resume = 1'b0;
    bus.out_ready = 1'b0; bus.in_valid = 1'b0; bus.in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.in_data = {$urandom, $urandom}; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    chk("reset/ctrl", 64'({pause, busy, done, ff_se, ram_se, ff_dir, ram_sd, bus.cmd_ready}),
        64'b0000_0001);
    chk("reset/streams", 64'({bus.out_valid, bus.in_ready, bus.out_last}), 64'd0);
    chk("reset/data", 64'(ff_sdi | ram_sdi | bus.out_data), 64'd0);
    chk("reset/checksum", 64'(checksum), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0; env_init = 1'b0;

    for (int v = 0; v < 6; v++)
      run_cmd($sformatf("vec%0d", v), vecs[v].ld, vecs[v].hold, vecs[v].with_resume,
              vecs[v].mode, vecs[v].seq, vecs[v].exp_beats, vecs[v].exp_pause);

    // Held pause released by a lone resume pulse.
    run_cmd("held", 1'b0, 1'b1, 1'b0, 0, 1'b0, NW, 1'b1);
    bus.resume = 1'b1;
    @(negedge clk);
    chk("resume/before_edge", 64'(pause), 64'd1);
    @(posedge clk); #1;
    bus.resume = 1'b0;
    chk("resume/cleared", 64'(pause), 64'd0);

    // Reset on the second FF beat aborts immediately.
    begin
      int beats;
      int guard;
      beats = 0; guard = 0;
      bus.out_ready = 1'b1;
      bus.cmd_valid = 1'b1; bus.cmd_load = 1'b0; bus.cmd_hold = 1'b1;
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
      while (beats < 2 && guard < 50) begin
        @(negedge clk);
        if (bus.out_valid && bus.out_ready) beats++;
        if (beats == 2) rst = 1'b1;
        @(posedge clk); #1;
        guard++;
      end
      chk("rst_mid/reached_beat2", 64'(beats), 64'd2);
      chk("rst_mid/state", 64'({ff_se, ram_se, pause, busy, done, bus.cmd_ready}), 64'b000001);
      rst = 1'b0;
    end

    // Randomized commands.
    for (int r = 0; r < 8; r++) begin
      logic ld, hold, res;
      ld = 1'($urandom); hold = 1'($urandom); res = 1'($urandom);
      run_cmd($sformatf("rnd%0d", r), ld, hold, res, 2, 1'b0, NW, hold);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
